// File: rtl/tick_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_pkg;

   localparam int unsigned DEFAULT_DIV_1HZ = 100000000;
   localparam int          DIV_WIDTH       = 28;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable divider channel: counter, active/shadow divisor,
// registered tick strobe and square output.
module tick_channel
   import tick_pkg::*;
#(
   parameter int               WIDTH   = DIV_WIDTH,
   parameter logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV_1HZ)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_enable,
   input  logic             i_cfg_we,
   input  logic [WIDTH-1:0] i_cfg_div,
   input  logic             i_cfg_restart,
   output logic             o_tick,
   output logic             o_square,
   output logic             o_pending
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_shadow;
   logic             r_pending;
   logic             r_tick;
   logic             r_square;

   logic w_run;
   logic w_wrap;

   assign w_run  = i_enable && (r_div != '0);
   assign w_wrap = w_run && (r_cnt == r_div - WIDTH'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_div     <= RST_DIV;
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_tick    <= 1'b0;
         r_square  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (w_wrap) begin
            r_cnt    <= '0;
            r_tick   <= 1'b1;
            r_square <= ~r_square;
            if (r_pending) begin
               r_div     <= r_shadow;
               r_pending <= 1'b0;
            end
         end else if (w_run) begin
            r_cnt <= r_cnt + WIDTH'(1);
         end

         // Config writes come last so they override the counting update.
         if (i_cfg_we) begin
            if (i_cfg_restart) begin
               r_div     <= i_cfg_div;
               r_cnt     <= '0;
               r_tick    <= 1'b0;
               r_pending <= 1'b0;
               r_square  <= r_square;
            end else if (!i_enable || (r_div == '0)) begin
               r_div <= i_cfg_div;
               if (r_cnt >= i_cfg_div) r_cnt <= '0;
            end else if (w_wrap) begin
               r_div <= i_cfg_div;
            end else begin
               r_shadow  <= i_cfg_div;
               r_pending <= 1'b1;
            end
         end
      end
   end

   assign o_tick    = r_tick;
   assign o_square  = r_square;
   assign o_pending = r_pending;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick source: CHANNELS independent dividers with a shared
// valid/ready configuration port.
module tick_generator
   import tick_pkg::*;
#(
   parameter int          CHANNELS    = 4,
   parameter int          WIDTH       = DIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [CHANNELS-1:0]           enable,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
   input  logic [WIDTH-1:0]              cfg_div,
   input  logic                          cfg_restart,
   output logic [CHANNELS-1:0]           tick,
   output logic [CHANNELS-1:0]           square
);

   logic [CHANNELS-1:0] w_pending;
   logic [CHANNELS-1:0] w_we;
   logic                w_ready;

   // Out-of-range channels read as ready so their requests are swallowed.
   always_comb begin
      w_ready = 1'b1;
      w_we    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(cfg_chan) == i) begin
            w_ready = ~w_pending[i];
            w_we[i] = cfg_valid & ~w_pending[i];
         end
      end
   end

   assign cfg_ready = w_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      tick_channel #(
         .WIDTH   (WIDTH),
         .RST_DIV (WIDTH'(DEFAULT_DIV))
      ) u_chan (
         .clock         (clock),
         .reset_n       (reset_n),
         .i_enable      (enable[g]),
         .i_cfg_we      (w_we[g]),
         .i_cfg_div     (cfg_div),
         .i_cfg_restart (cfg_restart),
         .o_tick        (tick[g]),
         .o_square      (square[g]),
         .o_pending     (w_pending[g])
      );
   end

endmodule
